// File: rtl/lockpick_pkg.sv
// lockpick_pkg: shared types and constants for the lockpick host driver.
//   host_state_t : host FSM states
//   ST_*         : core status encodings
//   KEY_BYTES    : bytes per key / result stream
package lockpick_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_SEND_A   = 3'd2,
    S_SEND_B   = 3'd3,
    S_WAIT_RSP = 3'd4,
    S_RECV     = 3'd5,
    S_DONE     = 3'd6
  } host_state_t;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ERROR  = 2'b01;
  localparam logic [1:0] ST_WIN    = 2'b10;
  localparam logic [1:0] ST_LOCKED = 2'b11;

  localparam int KEY_BYTES = 16;

endpackage

// File: rtl/lockpick_host.sv
// lockpick_host: host-side driver for the lockpick core byte-serial interface.
// Accepts two 128-bit keys on a valid/ready request, pulses start, streams
// key_a then key_b LSB byte first, collects 16 result bytes plus status and
// returns them on a one-cycle rsp_valid strobe. A watchdog aborts the
// transaction if the core stays silent for TIMEOUT_CYCLES cycles.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   req_valid/req_ready, key_a/key_b : request port
//   start, input_enable, input_data  : to core (registered)
//   output_valid, output_data, status: from core
//   rsp_valid, rsp_msg, rsp_status, rsp_timeout : response (registered)
//   busy                             : transaction in progress
module lockpick_host
  import lockpick_pkg::*;
#(
  parameter int BYTE_GAP       = 0,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [127:0] key_a,
  input  logic [127:0] key_b,
  output logic         start,
  output logic         input_enable,
  output logic [7:0]   input_data,
  input  logic         output_valid,
  input  logic [7:0]   output_data,
  input  logic [1:0]   status,
  output logic         rsp_valid,
  output logic [127:0] rsp_msg,
  output logic [1:0]   rsp_status,
  output logic         rsp_timeout,
  output logic         busy
);

  localparam int              WD_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0]      GAP_LAST  = 4'(BYTE_GAP);
  localparam logic [3:0]      BEAT_LAST = 4'(KEY_BYTES - 1);
  localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);

  host_state_t     state, state_nxt;
  logic [127:0]    key_sr_a, key_sr_b;
  logic [3:0]      beat_cnt, gap_cnt, byte_idx;
  logic [WD_W-1:0] wd_cnt;
  logic            sending, slot_end, send_done, wd_expire;

  // A beat slot is the data cycle plus BYTE_GAP idle cycles; gap_cnt==0 is
  // the data cycle and gap_cnt==BYTE_GAP closes the slot.
  assign sending   = (state == S_SEND_A) || (state == S_SEND_B);
  assign slot_end  = (gap_cnt == GAP_LAST);
  assign send_done = sending && slot_end && (beat_cnt == BEAT_LAST);
  // Last idle cycle the watchdog tolerates; a byte arriving now still counts.
  assign wd_expire = !output_valid && (wd_cnt == WD_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (req_valid) state_nxt = S_START;
      S_START:    state_nxt = S_SEND_A;
      S_SEND_A:   if (send_done) state_nxt = S_SEND_B;
      S_SEND_B:   if (send_done) state_nxt = S_WAIT_RSP;
      S_WAIT_RSP: begin
        if (output_valid)   state_nxt = S_RECV;
        else if (wd_expire) state_nxt = S_DONE;
      end
      S_RECV: begin
        if (output_valid && (byte_idx == BEAT_LAST)) state_nxt = S_DONE;
        else if (wd_expire)                          state_nxt = S_DONE;
      end
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Combinational outputs
  always_comb begin
    req_ready = (state == S_IDLE);
    busy      = (state != S_IDLE);
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      start        <= 1'b0;
      input_enable <= 1'b0;
      input_data   <= '0;
      rsp_valid    <= 1'b0;
      rsp_msg      <= '0;
      rsp_status   <= ST_IDLE;
      rsp_timeout  <= 1'b0;
      key_sr_a     <= '0;
      key_sr_b     <= '0;
      beat_cnt     <= '0;
      gap_cnt      <= '0;
      byte_idx     <= '0;
      wd_cnt       <= '0;
    end else begin
      start        <= (state == S_START);
      rsp_valid    <= (state == S_DONE);
      input_enable <= 1'b0;
      input_data   <= '0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            key_sr_a    <= key_a;
            key_sr_b    <= key_b;
            rsp_msg     <= '0;
            rsp_status  <= ST_IDLE;
            rsp_timeout <= 1'b0;
            beat_cnt    <= '0;
            gap_cnt     <= '0;
          end
        end
        S_SEND_A, S_SEND_B: begin
          if (gap_cnt == 4'd0) begin
            input_enable <= 1'b1;
            if (state == S_SEND_A) begin
              input_data <= key_sr_a[7:0];
              key_sr_a   <= {8'h00, key_sr_a[127:8]};
            end else begin
              input_data <= key_sr_b[7:0];
              key_sr_b   <= {8'h00, key_sr_b[127:8]};
            end
          end
          // beat_cnt wraps 15->0 at the end of SEND_A, ready for SEND_B
          if (slot_end) begin
            gap_cnt  <= '0;
            beat_cnt <= beat_cnt + 4'd1;
          end else begin
            gap_cnt  <= gap_cnt + 4'd1;
          end
          // WAIT_RSP starts with a fresh watchdog and byte index
          wd_cnt   <= '0;
          byte_idx <= '0;
        end
        S_WAIT_RSP, S_RECV: begin
          if (output_valid) begin
            wd_cnt                         <= '0;
            rsp_msg[{byte_idx, 3'b000} +: 8] <= output_data;
            byte_idx                       <= byte_idx + 4'd1;
            if (state == S_WAIT_RSP) rsp_status <= status;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
            if (wd_cnt == WD_LAST) rsp_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lockpick_host.sv
// tb_lockpick_host: two DUT lanes (BYTE_GAP 0 and 2) driven in parallel.
// Stimulus checks the key stream cycle by cycle from the beat schedule and
// pushes the expected response (data, status, timeout, cycle) into a
// per-lane queue; a monitor pops and compares on every rsp_valid.
module tb_lockpick_host;
  import lockpick_pkg::*;

  localparam int TC = 64;

  typedef struct packed {
    logic [127:0] msg;
    logic [1:0]   st;
    logic         to;
    int           cycle;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests  = 0;
  int failed = 0;

  logic         rst [2];
  logic         req_valid [2];
  logic         req_ready [2];
  logic [127:0] key_a [2];
  logic [127:0] key_b [2];
  logic         start [2];
  logic         ien [2];
  logic [7:0]   idata [2];
  logic         ovalid [2];
  logic [7:0]   odata [2];
  logic [1:0]   status [2];
  logic         rsp_valid [2];
  logic [127:0] rsp_msg [2];
  logic [1:0]   rsp_status [2];
  logic         rsp_timeout [2];
  logic         busy [2];

  exp_t exp_q [2][$];
  exp_t me;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    lockpick_host #(.BYTE_GAP(g * 2), .TIMEOUT_CYCLES(TC)) u_dut (
      .clk(clk), .rst(rst[g]),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]),
      .key_a(key_a[g]), .key_b(key_b[g]),
      .start(start[g]), .input_enable(ien[g]), .input_data(idata[g]),
      .output_valid(ovalid[g]), .output_data(odata[g]), .status(status[g]),
      .rsp_valid(rsp_valid[g]), .rsp_msg(rsp_msg[g]),
      .rsp_status(rsp_status[g]), .rsp_timeout(rsp_timeout[g]),
      .busy(busy[g])
    );
  end

  function automatic int gap(input int l);
    return l * 2;
  endfunction

  task automatic chk(input string nm, input int l, input logic [159:0] act,
                     input logic [159:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL lane%0d %s: got %0h expected %0h", l, nm, act, exp);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (rsp_valid[l] === 1'b1) begin
        if (exp_q[l].size() == 0) begin
          chk("unexpected_rsp_valid", l, 160'(rsp_valid[l]), 160'd0);
        end else begin
          me = exp_q[l].pop_front();
          chk("rsp_msg", l, 160'(rsp_msg[l]), 160'(me.msg));
          chk("rsp_status", l, 160'(rsp_status[l]), 160'(me.st));
          chk("rsp_timeout", l, 160'(rsp_timeout[l]), 160'(me.to));
          chk("rsp_cycle", l, 160'(cyc), 160'(me.cycle));
        end
      end
    end
  end

  task automatic reset_chk(input int l);
    rst[l] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", l, 160'({start[l], ien[l], idata[l], rsp_valid[l],
        rsp_status[l], rsp_timeout[l]}), 160'd0);
    chk("reset_msg", l, 160'(rsp_msg[l]), 160'd0);
    chk("reset_ready_busy", l, 160'({req_ready[l], busy[l]}), 160'b10);
    rst[l] = 1'b0;
  endtask

  // One transaction, entered and left at a negedge with the DUT idle.
  // dly[i] = idle cycles before result byte i; dly[i] >= TC means silence.
  task automatic xact(input int l, input logic [127:0] ka, input logic [127:0] kb,
                      input logic [127:0] resp, input logic [1:0] st,
                      input logic [15:0][7:0] dly, input bit mid_rst);
    int G, T, W, R, X, c, off, n, got, k;
    logic en;
    logic [7:0] dat;
    exp_t e;
    G = gap(l);
    X = 0;
    chk("req_ready_idle", l, 160'(req_ready[l]), 160'd1);
    req_valid[l] = 1'b1;
    key_a[l] = ka;
    key_b[l] = kb;
    @(posedge clk); #1;
    T = cyc;
    req_valid[l] = 1'b0;
    W = T + 1 + 32 * (1 + G);
    while (1) begin
      @(negedge clk);
      c = cyc; off = c - T - 2; en = 1'b0; dat = 8'h00; n = -1;
      if (off >= 0 && off % (1 + G) == 0 && off / (1 + G) < 32) begin
        n = off / (1 + G);
        en = 1'b1;
        dat = (n < 16) ? ka[8*n +: 8] : kb[8*(n-16) +: 8];
      end
      chk("send_cycle", l, 160'({start[l], ien[l], idata[l], busy[l], req_ready[l]}),
          160'({(c == T + 1), en, dat, 1'b1, 1'b0}));
      if (mid_rst && n == 20) begin
        rst[l] = 1'b1;
        ovalid[l] = 1'b0;
        req_valid[l] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_outs", l, 160'({start[l], ien[l], idata[l], rsp_valid[l],
            rsp_status[l], rsp_timeout[l], busy[l]}), 160'd0);
        chk("midrst_msg", l, 160'(rsp_msg[l]), 160'd0);
        chk("midrst_ready", l, 160'(req_ready[l]), 160'd1);
        rst[l] = 1'b0;
        return;
      end
      if (c == W) break;
      // noise the core and request port cannot act on in these states
      req_valid[l] = 1'($urandom_range(0, 1));
      key_a[l] = {$urandom, $urandom, $urandom, $urandom};
      key_b[l] = {$urandom, $urandom, $urandom, $urandom};
      ovalid[l] = (c < W - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      odata[l] = 8'($urandom);
    end
    req_valid[l] = 1'b0;

    // Expected response from the delay plan
    e.msg = '0; e.st = ST_IDLE; e.to = 1'b0; e.cycle = 0;
    R = W; got = 0;
    for (int i = 0; i < KEY_BYTES; i++) begin
      if (int'(dly[i]) >= TC) begin
        e.to = 1'b1;
        e.cycle = R + TC + 1;
        break;
      end
      X = R + int'(dly[i]);
      e.msg[8*i +: 8] = resp[8*i +: 8];
      if (i == 0) e.st = st;
      R = X + 1;
      got++;
    end
    if (!e.to) e.cycle = X + 2;
    exp_q[l].push_back(e);

    for (int i = 0; i < got; i++) begin
      repeat (int'(dly[i])) begin
        @(posedge clk); #1;
        odata[l] = 8'($urandom);
        status[l] = 2'($urandom_range(0, 3));
      end
      ovalid[l] = 1'b1;
      odata[l] = resp[8*i +: 8];
      status[l] = (i == 0) ? st : 2'($urandom_range(0, 3));
      @(posedge clk); #1;
      ovalid[l] = 1'b0;
      status[l] = 2'($urandom_range(0, 3));
    end
    while (cyc < e.cycle) @(negedge clk);
    // rsp_* must hold until the next accepted request; k==0 is back-to-back
    k = $urandom_range(0, 2);
    repeat (k) @(negedge clk);
    chk("rsp_hold", l, 160'({rsp_timeout[l], rsp_status[l], rsp_msg[l]}),
        160'({e.to, e.st, e.msg}));
  endtask

  task automatic run_lane(input int l);
    logic [15:0][7:0] dly;
    logic [127:0] r;
    reset_chk(l);
    dly = '0;
    xact(l, 128'h0F0E0D0C0B0A09080706050403020100,
         128'h1F1E1D1C1B1A19181716151413121110,
         {4{32'hBAD0BAD0}}, ST_ERROR, dly, 1'b0);
    dly = '0; dly[0] = 8'(TC);
    xact(l, {4{$urandom}}, {4{$urandom}}, {4{$urandom}}, ST_WIN, dly, 1'b0);
    dly = '0; dly[3] = 8'd2; dly[5] = 8'(TC);
    xact(l, {4{$urandom}}, {4{$urandom}}, {$urandom, $urandom, $urandom, $urandom},
         ST_LOCKED, dly, 1'b0);
    dly = '0; dly[0] = 8'(TC - 1); dly[7] = 8'(TC - 1);
    xact(l, {4{$urandom}}, {4{$urandom}}, {$urandom, $urandom, $urandom, $urandom},
         ST_ERROR, dly, 1'b0);
    dly = '0;
    xact(l, {$urandom, $urandom, $urandom, $urandom},
         {$urandom, $urandom, $urandom, $urandom}, {4{$urandom}}, ST_ERROR, dly, 1'b1);
    xact(l, {$urandom, $urandom, $urandom, $urandom},
         {$urandom, $urandom, $urandom, $urandom}, {4{32'hFACEFACE}}, ST_WIN, dly, 1'b0);
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < KEY_BYTES; i++) dly[i] = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) dly[$urandom_range(0, 15)] = 8'(TC - 1 + $urandom_range(0, 1));
      r = {$urandom, $urandom, $urandom, $urandom};
      xact(l, {$urandom, $urandom, $urandom, $urandom},
           {$urandom, $urandom, $urandom, $urandom}, r, 2'($urandom_range(0, 3)), dly, 1'b0);
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    for (int l = 0; l < 2; l++) begin
      rst[l] = 1'b1; req_valid[l] = 1'b0; key_a[l] = '0; key_b[l] = '0;
      ovalid[l] = 1'b0; odata[l] = '0; status[l] = ST_IDLE;
    end
    fork
      run_lane(0);
      run_lane(1);
    join
    for (int l = 0; l < 2; l++)
      chk("rsp_queue_drained", l, 160'(exp_q[l].size()), 160'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL sim_watchdog: run exceeded time limit, tests %0d failed %0d", tests, failed);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/lockpick_host.md
# lockpick_host

Host-side driver for the lockpick game core's byte-serial interface. It accepts two 128-bit keys over a valid/ready request port and issues the one-cycle `start` pulse. It streams both keys LSB-byte-first with `input_enable`, then collects the 16-byte result stream and the 2-bit status. It returns them on a one-cycle response strobe, with a watchdog for a silent or stalled core.

## Interface
- `BYTE_GAP`, default 0: idle cycles inserted after every key byte beat (0..15).
- `TIMEOUT_CYCLES`, default 64: maximum cycles without a received byte before the transaction aborts (≥2).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request strobe.
- `req_ready` out 1: high only in IDLE.
- `key_a` in 128, `key_b` in 128: keys, sampled on handshake.
- `start` out 1: to core start.
- `input_enable` out 1: key byte qualifier.
- `input_data` out 8: key byte.
- `output_valid` in 1: core result byte qualifier.
- `output_data` in 8: core result byte.
- `status` in 2: core status (00 idle, 01 error, 10 win, 11 locked out).
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_msg` out 128: collected result, byte k at `[8k+7:8k]`.
- `rsp_status` out 2: status sampled with result byte 0.
- `rsp_timeout` out 1: watchdog abort flag, valid with `rsp_valid`.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- States: IDLE, START, SEND_A, SEND_B, WAIT_RSP, RECV, DONE.
- IDLE:
  - On `req_valid & req_ready`, latch `key_a`/`key_b` into shift registers.
  - Clear `rsp_msg`, `rsp_status` and `rsp_timeout`, then go to START.
- START: `start`=1 for exactly one cycle, then SEND_A.
- SEND_A / SEND_B:
  - Beat k (k=0..15) drives `input_data`=key[8k+7:8k] with `input_enable`=1.
  - Each beat is followed by `BYTE_GAP` cycles with `input_enable`=0 and `input_data`=0.
  - The gap also applies after beat 15 of SEND_A and of SEND_B.
  - After 16 beats: SEND_A→SEND_B, SEND_B→WAIT_RSP.
- WAIT_RSP:
  - The watchdog counts cycles.
  - First `output_valid`=1: store `output_data` as byte 0 and `status` into `rsp_status`, then go to RECV.
- RECV:
  - Each `output_valid`=1 cycle stores the next byte; the index is a 4-bit counter.
  - After byte 15, go to DONE.
  - Cycles with `output_valid`=0 are tolerated but count toward the watchdog.
- Watchdog:
  - Reset to 0 on entering WAIT_RSP and on every received byte.
  - On reaching `TIMEOUT_CYCLES` in WAIT_RSP or RECV: set `rsp_timeout`=1, go to DONE.
  - Bytes already captured are kept; uncaptured bytes remain 0.
- DONE: `rsp_valid`=1 for one cycle, then IDLE. `rsp_*` holds until the next accepted request.
- `req_valid` while not IDLE is ignored; there is no queueing.
- `output_valid` seen in IDLE through SEND_B is ignored.

## Timing
- Reset values:
  - Registered outputs `start`, `input_enable`, `input_data`, `rsp_valid`, `rsp_msg`, `rsp_status`, `rsp_timeout` reset to 0.
  - State returns to IDLE, so combinational `req_ready` reads 1 and `busy` reads 0.
- `start`, `input_enable`, `input_data` and `rsp_valid` are registered; `req_ready` and `busy` are combinational from state.
- Handshake at edge T:
  - `start`=1 during cycle T+1.
  - With `BYTE_GAP`=0, `input_enable`=1 during T+2..T+33 (A bytes T+2..T+17, B bytes T+18..T+33).
  - General: the beat n (0..31) index n is at T+2+n·(1+`BYTE_GAP`).
- RECV capturing byte 15 at edge E gives `rsp_valid`=1 during E+1.
- Timeout: with no `output_valid`, `rsp_valid` is asserted `TIMEOUT_CYCLES`+1 cycles after entering WAIT_RSP.
- Reset mid-transaction: all outputs are 0 in the cycle after `rst`, captured data is discarded, and no `rsp_valid` is produced.
- Back-to-back requests: the earliest next acceptance is the cycle after DONE.

## Structure
- Shared package `lockpick_pkg` holds:
  - `host_state_t` enum.
  - Status constants `ST_IDLE`=2'b00, `ST_ERROR`=2'b01, `ST_WIN`=2'b10, `ST_LOCKED`=2'b11.
  - `KEY_BYTES`=16.
- Single module; no sub-module. Key and result shift registers, beat/gap counters and the watchdog are inline.

## Test plan
- Reset: hold `rst`=1 for 2 cycles → all outputs 0, `req_ready`=1, `busy`=0.
- Key order: `key_a`=128'h0F0E…0100, `key_b`=128'h1F1E…1110, `BYTE_GAP`=0.
  - Required: `start` pulse at T+1.
  - `input_data` = 00,01,…,1F on T+2..T+33.
- Response: the model returns bytes D0,BA,D0,BA… (16) with `status`=01 → `rsp_msg`={4{32'hBAD0BAD0}}, `rsp_status`=01, `rsp_timeout`=0, `rsp_valid` one cycle.
- Timeout: no `output_valid`, `TIMEOUT_CYCLES`=64 → `rsp_valid` with `rsp_timeout`=1 and `rsp_msg`=0. Repeat with 5 bytes then silence → bytes 0..4 kept.
- Gap: `BYTE_GAP`=2 → `input_enable` pattern 1,0,0 repeated 32 times, 96 cycles; data correct on enabled cycles.
- Reset mid-SEND_B (beat 20) → next cycle `input_enable`=0 and `req_ready`=1, no `rsp_valid`, and a new request then completes normally with `status`=10 and `rsp_msg`={4{32'hFACEFACE}}.
